apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 2: number of requester ports; legal range 2..8.
REQ-002 SHALL have parameter APB_ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter APB_DATA_WIDTH, default 32: data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: ACCESS wait limit; used only with APB_ARB_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port req_i, input, NB_REQ: per-requester transfer request, held high until granted.
REQ-008 SHALL have port addr_i, input, NB_REQ*APB_ADDR_WIDTH: per-requester address, packed with slice k for requester k.
REQ-009 SHALL have port we_i, input, NB_REQ: per-requester write enable.
REQ-010 SHALL have port wdata_i, input, NB_REQ*APB_DATA_WIDTH: per-requester write data.
REQ-011 SHALL have port gnt_o, output, NB_REQ: one-hot grant pulse; the request is captured in that cycle.
REQ-012 SHALL have port rvalid_o, output, NB_REQ: one-hot one-cycle response pulse.
REQ-013 SHALL have port rdata_o, output, APB_DATA_WIDTH: read data, valid with rvalid_o; zero for writes and errors.
REQ-014 SHALL have port err_o, output, 1: error flag, valid with rvalid_o.
REQ-015 SHALL have ports paddr, pwdata, pwrite, psel, penable as outputs and prdata, pready, pslverr as inputs: the APB master side, with APB_BUS Master widths.

Function
REQ-016 SHALL implement an FSM with states IDLE, SETUP, ACCESS and DECERR.
REQ-017 In IDLE, when any req_i is high, SHALL assert gnt_o for the round-robin winner combinationally in that cycle.
- On the same cycle, the winner's addr, we and wdata SHALL be latched.
REQ-018 After a grant, SHALL go to SETUP if the address lies in the peripheral window 0x1A10_0000..0x1A11_7FFF inclusive; otherwise SHALL go to DECERR.
REQ-019 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then go to ACCESS.
REQ-020 ACCESS SHALL hold psel=1 and penable=1, and paddr, pwdata and pwrite stable, until pready=1.
- On the pready cycle, SHALL return to IDLE.
REQ-021 In the cycle after the pready cycle, SHALL pulse rvalid_o for the owner.
- err_o SHALL equal the captured pslverr.
- rdata_o SHALL equal the captured prdata for a read and 0 for a write.
REQ-022 DECERR SHALL last one cycle with rvalid_o pulsed for the owner, err_o=1, rdata_o=0 and psel kept at 0, then return to IDLE.
REQ-023 A new grant SHALL be possible in the same cycle as the previous rvalid_o, giving a minimum APB transfer period of 3 cycles.
REQ-024 Round-robin arbitration:
- After a grant to requester k, requester k+1 mod NB_REQ SHALL have highest priority.
- The pointer SHALL update only on a grant.
- Simultaneous requests SHALL resolve by this priority.
REQ-025 gnt_o SHALL be 0 outside IDLE, and requests arriving in other states SHALL wait.
REQ-026 Outside SETUP and ACCESS, psel and penable SHALL be 0.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be as follows:
- FSM in IDLE and the round-robin pointer at requester 0.
- psel, penable, pwrite, gnt_o, rvalid_o and err_o at 0.
- paddr, pwdata and rdata_o at 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no rvalid_o ever issued for it.

Configuration
REQ-029 With the macro APB_ARB_TIMEOUT_EN defined, ACCESS SHALL run a wait-cycle counter.
- When TIMEOUT_CYCLES consecutive ACCESS cycles pass with pready=0, SHALL drop psel and penable and return to IDLE.
- SHALL then pulse rvalid_o the next cycle with err_o=1 and rdata_o=0.
- The counter SHALL clear on entering SETUP.
REQ-030 With APB_ARB_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely, with no counter logic present.

Structure
REQ-031 A package apb_arb_pkg SHALL hold:
- the FSM state enum;
- the window constants APB_WIN_START=0x1A10_0000 and APB_WIN_END=0x1A11_7FFF.
REQ-032 The round-robin winner and pointer logic SHALL be a sub-module apb_rr_arb, parameterised by NB_REQ, with inputs req and advance and outputs one-hot gnt.

Verification
REQ-033 Single read: requester 0 reads 0x1A10_1000 with prdata=0xCAFE_0001 and pready=1 in the first ACCESS cycle.
- Required: gnt at T, SETUP at T+1, ACCESS at T+2, rvalid_o=01 at T+3 with rdata_o=0xCAFE_0001 and err_o=0.
REQ-034 Contention: req_i=11 held for 4 grants after reset.
- Required: grant order 0,1,0,1.
REQ-035 Decode error: write to 0x2000_0000.
- Required: rvalid_o at T+1 with err_o=1 and no psel.
REQ-036 Wait states and slave error: pready low for 3 ACCESS cycles, then pslverr=1.
- Required: paddr and pwdata stable throughout; rvalid_o with err_o=1.
REQ-037 Reset mid-operation: rst=1 during ACCESS.
- Required: psel=0 the next cycle and no rvalid_o.
REQ-038 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held at 0.
- Required: psel falls after 4 ACCESS cycles, then rvalid_o with err_o=1.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
// Latency: none (package only).
// Backpressure: n/a.
//
// Holds the transfer FSM state encoding, the peripheral address window
// and a helper that tests an address against that window.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_t;

  // Inclusive bounds of the address range that is forwarded to APB.
  localparam logic [31:0] APB_WIN_START = 32'h1A10_0000;
  localparam logic [31:0] APB_WIN_END   = 32'h1A11_7FFF;

  // Callers zero-extend their address to 64 bits, so the test is
  // independent of the configured address width.
  function automatic logic in_apb_window(input logic [63:0] addr);
    return (addr >= {32'h0, APB_WIN_START}) && (addr <= {32'h0, APB_WIN_END});
  endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Round-robin arbiter: one-hot winner among NB_REQ requests.
// Latency: combinational grant; priority pointer updates on the clock edge.
// Backpressure: none; the caller masks req while it cannot accept a grant.
//
// Ports: clk, rst (sync, active-high); req (request vector); advance
// (a grant is being taken this cycle); gnt (one-hot winner).
module apb_rr_arb #(
  parameter int NB_REQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB_REQ-1:0] req,
  input  logic              advance,
  output logic [NB_REQ-1:0] gnt
);

  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_idx;
  logic          found;

  // Scan starting at the pointer; the first active request wins.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= NB_REQ) j = j - NB_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  // After a grant to k, requester k+1 (wrapping) becomes highest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (int'(win_idx) == NB_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Arbitrates NB_REQ requesters onto one APB master port, with decode errors.
// Latency: grant same cycle as request; response 3 cycles after grant plus wait states (1 for decode error).
// Backpressure: requests hold until granted; grants only issue while the FSM is idle.
//
// Ports: clk, rst (sync, active-high); per-requester req_i/addr_i/we_i/wdata_i
// (packed, slice k = requester k); gnt_o one-hot grant; rvalid_o/rdata_o/err_o
// response; paddr/pwdata/pwrite/psel/penable/prdata/pready/pslverr APB master.
// Optional macro APB_ARB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES
// cycles without pready and return an error response.
import apb_arb_pkg::*;

module apb_master_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NB_REQ-1:0]                  req_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic [NB_REQ-1:0]                  we_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
  output logic [NB_REQ-1:0]                  gnt_o,
  output logic [NB_REQ-1:0]                  rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]          rdata_o,
  output logic                               err_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr,
  output logic [APB_DATA_WIDTH-1:0]          pwdata,
  output logic                               pwrite,
  output logic                               psel,
  output logic                               penable,
  input  logic [APB_DATA_WIDTH-1:0]          prdata,
  input  logic                               pready,
  input  logic                               pslverr
);

  apb_state_t state_q, state_d;

  logic [NB_REQ-1:0]         arb_req;
  logic [NB_REQ-1:0]         gnt;
  logic [NB_REQ-1:0]         owner_q;
  logic [APB_ADDR_WIDTH-1:0] sel_addr;
  logic [APB_DATA_WIDTH-1:0] sel_wdata;
  logic                      sel_we;
  logic                      in_win;
  logic                      to_hit;

  // Only offer requests to the arbiter when a grant can actually be taken;
  // this also keeps the pointer frozen outside IDLE and during reset.
  assign arb_req = (state_q == IDLE && !rst) ? req_i : '0;
  assign gnt_o   = gnt;

  apb_rr_arb #(.NB_REQ(NB_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (|gnt),
    .gnt     (gnt)
  );

  // One-hot mux of the winner's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr  = sel_addr  | addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        sel_wdata = sel_wdata | wdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        sel_we    = sel_we    | we_i[k];
      end
    end
  end

  assign in_win = in_apb_window(64'(sel_addr));

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Counts ACCESS cycles without pready; restarts for every transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign to_hit = !pready && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    psel    = 1'b0;
    penable = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) state_d = in_win ? SETUP : DECERR;
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || to_hit) state_d = IDLE;
      end
      DECERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      rvalid_o <= '0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_o <= '0;
      err_o    <= 1'b0;
      rdata_o  <= '0;

      // Capture the request on its grant cycle; paddr/pwdata/pwrite then
      // stay stable through SETUP and ACCESS.
      if (|gnt) begin
        owner_q <= gnt;
        paddr   <= sel_addr;
        pwdata  <= sel_wdata;
        pwrite  <= sel_we;
        // Out-of-window: the response pulse coincides with the DECERR cycle.
        if (!in_win) begin
          rvalid_o <= gnt;
          err_o    <= 1'b1;
        end
      end

      if (state_q == ACCESS) begin
        if (pready) begin
          rvalid_o <= owner_q;
          err_o    <= pslverr;
          rdata_o  <= (pwrite || pslverr) ? '0 : prdata;
        end else if (to_hit) begin
          rvalid_o <= owner_q;
          err_o    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TOC = 4;
  localparam int TO  = 4;
`else
  localparam int TOC = 255;
  localparam int TO  = 1 << 30;
`endif

  logic              clk;
  logic              rst;
  logic [NB-1:0]     req_i, we_i, gnt_o, rvalid_o;
  logic [NB*AW-1:0]  addr_i;
  logic [NB*DW-1:0]  wdata_i;
  logic [DW-1:0]     rdata_o, pwdata, prdata;
  logic              err_o;
  logic [AW-1:0]     paddr;
  logic              pwrite, psel, penable, pready, pslverr;

  apb_master_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    int            n;       // wait cycles before pready
    logic          err;
    logic [DW-1:0] prdata;
    int            setup_cyc;
  } plan_t;

  typedef struct {
    logic [NB-1:0] owner;
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    got_order[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: pending requests, RR pointer, next free cycle.
  logic [NB-1:0] pend;
  logic [AW-1:0] p_addr[NB];
  logic [NB-1:0] p_we;
  logic [DW-1:0] p_wdata[NB];
  int            ptr, free_at;
  logic          force_vld;
  int            force_n;
  logic          force_err;
  logic [DW-1:0] force_prdata;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_window(input logic [AW-1:0] a);
    return (a >= 32'h1A10_0000) && (a <= 32'h1A11_7FFF);
  endfunction

  task automatic grant_model(input int w);
    plan_t p;
    exp_t  e;
    int    len;
    pend[w] = 1'b0;
    ptr     = (w + 1) % NB;
    p.addr  = p_addr[w];
    p.wdata = p_wdata[w];
    p.we    = p_we[w];
    if (force_vld) begin
      p.n = force_n; p.err = force_err; p.prdata = force_prdata;
      force_vld = 1'b0;
    end else begin
      p.n = $urandom_range(0, 3); p.err = ($urandom_range(0, 3) == 0); p.prdata = $urandom;
    end
    p.setup_cyc = cyc + 1;
    e.owner = '0;
    e.owner[w] = 1'b1;
    if (in_window(p.addr)) begin
      plan_q.push_back(p);
      if (p.n >= TO) begin
        len = TO; e.err = 1'b1; e.rdata = '0;
      end else begin
        len = p.n + 1; e.err = p.err; e.rdata = (p.we || p.err) ? '0 : p.prdata;
      end
      e.cyc   = cyc + 2 + len;
      free_at = e.cyc;
    end else begin
      e.err = 1'b1; e.rdata = '0; e.cyc = cyc + 1;
      free_at = cyc + 2;
    end
    exp_q.push_back(e);
  endtask

  // One cycle: drive requests at negedge, check the grant against the model.
  task automatic step();
    logic [NB-1:0] exp_g;
    int w;
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      req_i[k] = pend[k];
      we_i[k]  = p_we[k];
      addr_i[k*AW +: AW]  = p_addr[k];
      wdata_i[k*DW +: DW] = p_wdata[k];
    end
    #1;
    exp_g = '0;
    w = -1;
    if (!rst && cyc >= free_at) begin
      for (int i = 0; i < NB; i++) begin
        int j;
        j = (ptr + i) % NB;
        if (w < 0 && pend[j]) w = j;
      end
    end
    if (w >= 0) exp_g[w] = 1'b1;
    chk(gnt_o == exp_g, "gnt", gnt_o, exp_g);
    if (gnt_o != '0) got_order.push_back(gnt_o[1] ? 1 : 0);
    if (w >= 0) grant_model(w);
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    pend[k] = 1'b1; p_addr[k] = a; p_we[k] = we; p_wdata[k] = wd;
  endtask

  task automatic new_rand_req(input int k);
    logic [AW-1:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'h1A10_0000;
      1: a = 32'h1A11_7FFF;
      2: a = 32'h1A0F_FFFF;
      3: a = 32'h1A11_8000;
      4, 5: a = 32'h1A10_0000 + $urandom_range(0, 32'h17FFF);
      6: a = $urandom;
      default: a = 32'h2000_0000;
    endcase
    set_req(k, a, 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (pend != '0 || exp_q.size() != 0); i++) step();
    chk(pend == '0 && exp_q.size() == 0, "drain", {pend, 32'(exp_q.size())}, 0);
  endtask

  // APB slave: consumes one plan per SETUP, checks bus stability, drives pready.
  initial begin
    plan_t cur;
    int wc;
    cur = '{default: 0};
    wc = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pready = 1'b0;
      end else if (psel && !penable) begin
        chk(plan_q.size() != 0, "psel_expected", paddr, 0);
        if (plan_q.size() != 0) begin
          cur = plan_q.pop_front();
          wc  = 0;
          chk(cyc == cur.setup_cyc, "setup_time", cyc, cur.setup_cyc);
          chk(paddr == cur.addr && pwrite == cur.we, "setup_addr", {pwrite, paddr}, {cur.we, cur.addr});
        end
        pready = 1'b0;
      end else if (psel && penable) begin
        chk(paddr == cur.addr && pwrite == cur.we && pwdata == cur.wdata, "access_stable",
            {pwrite, paddr, pwdata}, {cur.we, cur.addr, cur.wdata});
        if (wc == cur.n) begin
          pready = 1'b1; prdata = cur.prdata; pslverr = cur.err;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        end
        wc++;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever rvalid_o is seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (rvalid_o != '0) begin
          chk(exp_q.size() != 0, "rvalid_expected", rvalid_o, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(rvalid_o == e.owner && err_o == e.err && rdata_o == e.rdata, "resp",
                {rvalid_o, err_o, rdata_o}, {e.owner, e.err, e.rdata});
            chk(cyc == e.cyc, "resp_time", cyc, e.cyc);
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          chk(1'b0 == 1'b1 && rvalid_o != '0, "resp_missing", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_ord[4];
    int req_made;
    int acc;
    exp_ord = '{0, 1, 0, 1};
    rst = 1'b1;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    pend = '0; p_we = '0; ptr = 0; free_at = 0; force_vld = 1'b0;
    force_n = 0; force_err = 1'b0; force_prdata = '0;
    for (int k = 0; k < NB; k++) begin p_addr[k] = '0; p_wdata[k] = '0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk({psel, penable, pwrite, gnt_o, rvalid_o, err_o} == '0, "rst_ctrl",
        {psel, penable, pwrite, gnt_o, rvalid_o, err_o}, 0);
    chk(paddr == '0 && pwdata == '0 && rdata_o == '0, "rst_data", {paddr, pwdata}, 0);
    rst = 1'b0;

    // Contention: both requesters held for four grants.
    got_order.delete();
    set_req(0, 32'h2000_0000, 1'b1, 32'h0);
    set_req(1, 32'h2000_0004, 1'b1, 32'h1);
    req_made = 2;
    for (int i = 0; i < 40 && got_order.size() < 4; i++) begin
      step();
      for (int k = 0; k < NB; k++)
        if (!pend[k] && req_made < 4) begin pend[k] = 1'b1; req_made++; end
    end
    chk(got_order.size() == 4, "rr_count", got_order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (got_order.size() > i) chk(got_order[i] == exp_ord[i], "rr_order", got_order[i], exp_ord[i]);
    drain();

    // Single read with zero wait states.
    set_req(0, 32'h1A10_1000, 1'b0, 32'h0);
    force_vld = 1'b1; force_n = 0; force_err = 1'b0; force_prdata = 32'hCAFE_0001;
    drain();

    // Decode error on a write.
    set_req(1, 32'h2000_0000, 1'b1, 32'hDEAD_BEEF);
    drain();

    // Three wait states then slave error on a write.
    set_req(0, 32'h1A11_0004, 1'b1, 32'h1234_5678);
    force_vld = 1'b1; force_n = 3; force_err = 1'b1; force_prdata = 32'h5555_AAAA;
    drain();

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never ready: ACCESS must give up after TO cycles.
    set_req(1, 32'h1A10_0100, 1'b0, 32'h0);
    force_vld = 1'b1; force_n = 1000; force_err = 1'b0; force_prdata = 32'h0;
    step();
    acc = 0;
    repeat (8) begin
      step();
      if (psel && penable) acc++;
    end
    chk(acc == TO, "timeout_access_cycles", acc, TO);
    drain();
`else
    acc = 0;
`endif

    // Reset during ACCESS aborts the transfer silently and resets the pointer.
    set_req(0, 32'h1A10_0010, 1'b0, 32'h0);
    force_vld = 1'b1; force_n = 20; force_err = 1'b0; force_prdata = 32'h0;
    step();
    step();
    step();
    chk(psel && penable, "pre_rst_access", {psel, penable}, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); plan_q.delete(); ptr = 0; free_at = 0; force_vld = 1'b0;
    @(negedge clk);
    #1;
    chk(!psel && !penable && rvalid_o == '0, "rst_abort", {psel, penable, rvalid_o}, 0);
    rst = 1'b0;
    got_order.delete();
    set_req(0, 32'h3000_0000, 1'b0, 32'h0);
    set_req(1, 32'h3000_0004, 1'b0, 32'h0);
    drain();
    chk(got_order.size() > 0 && got_order[0] == 0, "rst_ptr", got_order.size() > 0 ? got_order[0] : -1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NB; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0) new_rand_req(k);
      step();
    end
    drain();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
